seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Sequential restoring divider, the inverse datapath of the add-shift multiplier.
//  Computes Dividend / Divisor with one shift-subtract step per clock.
//  Run/Done handshake matches the multiplier Processor top level, so the same
//  switches, hex drivers and testbench style are reused.
// PARAMETERS
//  WIDTH  8  operand, quotient and remainder width in bits (>= 2)
// PORTS
//  Clk        in   1      system clock; all state changes on the rising edge
//  Reset      in   1      synchronous, active-high; one clock, one synchronous active-high reset
//  Run        in   1      start request (level); sampled only in IDLE and HALT
//  Dividend   in   WIDTH  latched on the start edge only
//  Divisor    in   WIDTH  latched on the start edge only
//  Quotient   out  WIDTH  registered result; held until the next completion
//  Remainder  out  WIDTH  registered result; held until the next completion
//  Done       out  1      high iff state == HALT
//  DivByZero  out  1      registered flag; set when the latched Divisor == 0
// BEHAVIOUR
//  - Reset: state IDLE; Quotient, Remainder, Done, DivByZero = 0; internal regs = 0.
//    Reset wins over every other event, including mid-COMPUTE (the result is discarded).
//  - FSM states: IDLE, COMPUTE, [FIXUP], HALT.
//  - IDLE, Run=1: latch the operands, count <= 0.
//    - Divisor==0: go to HALT; DivByZero <= 1, Quotient <= all ones, Remainder <= Dividend.
//    - Otherwise: go to COMPUTE; DivByZero <= 0.
//  - IDLE, Run=0: stay in IDLE.
//  - COMPUTE: partial remainder P is WIDTH+1 bits, Q is a WIDTH-bit shift register
//    (loaded with the dividend), D is the latched divisor.
//    - Each step: {P,Q} <<= 1; diff = P - {1'b0,D} (WIDTH+1 bits, unsigned).
//    - diff[WIDTH]==0: P <= diff, Q[0] <= 1. Otherwise P is kept, Q[0] <= 0.
//    - count++. At count==WIDTH-1, go to HALT (or FIXUP) and copy Q and P[WIDTH-1:0]
//      into Quotient and Remainder.
//    - Run and the operand inputs are ignored during COMPUTE.
//  - HALT: Done=1. Stay while Run=1 (no auto-restart). Run=0 -> IDLE on the next edge.
//    Done falls when HALT is left.
//  - Latency (unsigned): start edge + WIDTH edges, so Done is high after WIDTH+1 edges.
//    Divide-by-zero: Done is high after 1 edge.
//  - Outputs never show intermediate values; the previous result stays visible
//    until the new one is written.
//  - Arithmetic: unsigned by default. Quotient = floor(A/B), Remainder = A mod B,
//    so A == Q*B + R and R < B.
// CONFIGURATION
//  Macro SEQ_DIVIDER_SIGNED_EN:
//  - Defined: operands are two's complement.
//    - The start edge latches |A| and |B| and the two sign bits.
//    - A FIXUP state after COMPUTE negates Q when sign(A) != sign(B), and negates R
//      when A is negative (truncation toward zero; R takes the sign of A).
//    - Latency is WIDTH+2 edges.
//    - The most-negative value divided by -1 gives Q = most-negative value (wraps), R = 0.
//    - Divide-by-zero result is unchanged: Q = all ones (-1), R = Dividend.
//  - Undefined: the FIXUP state and all sign logic are absent; unsigned only.
// TESTING  (WIDTH=8)
//  1. Dividend=200, Divisor=7, pulse Run -> Done after 9 edges; Q=28 (0x1C), R=4.
//  2. 5/9 -> Q=0, R=5.  255/1 -> Q=255, R=0.  255/255 -> Q=1, R=0.
//  3. 77/0 -> after 1 edge: Done=1, DivByZero=1, Q=0xFF, R=77.
//     A following 10/3 clears DivByZero; Q=3, R=1.
//  4. Hold Run=1 past Done -> stays in HALT, no second run.
//     Change operands during COMPUTE -> the result is unaffected.
//     Run=0 -> IDLE next edge, Done=0.
//  5. Assert Reset on the 4th COMPUTE edge -> next edge: IDLE, Q=R=0, Done=0.
//     A new 100/10 then gives Q=10, R=0.
//  6. [SEQ_DIVIDER_SIGNED_EN] -100/7 -> Q=0xF2 (-14), R=0xFE (-2), Done after 10 edges.
//     -128/-1 -> Q=0x80, R=0.  100/-7 -> Q=0xF2, R=2.

Source files
------------

// File: rtl/seq_divider_if.sv
// Run/Done handshake and operand/result bus of the sequential divider.
// The master drives the request and operands; the slave (the divider) returns the results.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Run;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Run, Dividend, Divisor,
    input  Quotient, Remainder, Done, DivByZero
  );

  modport slave (
    input  Run, Dividend, Divisor,
    output Quotient, Remainder, Done, DivByZero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: one shift-subtract step per clock, Run/Done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a FIXUP state).
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  seq_divider_if.slave bus
);
  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FIXUP, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_HALT} state_t;
`endif

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_div_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_p_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_p_next;
  logic [WIDTH-1:0] w_q_next;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_a_neg;
  logic r_b_neg;
  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg = bus.Dividend[WIDTH-1];
  assign w_b_neg = bus.Divisor[WIDTH-1];
  // Magnitude of the most-negative value wraps to itself, which is its correct unsigned magnitude.
  assign w_a_mag = w_a_neg ? -bus.Dividend : bus.Dividend;
  assign w_b_mag = w_b_neg ? -bus.Divisor  : bus.Divisor;
`else
  assign w_a_mag = bus.Dividend;
  assign w_b_mag = bus.Divisor;
`endif

  assign w_div_zero = (bus.Divisor == '0);
  assign w_last     = (r_count == LAST);

  // The restored partial remainder is always below the divisor, so only the
  // shifted value needs the extra bit; r_p itself fits in WIDTH bits.
  assign w_p_shift = {r_p, r_q[WIDTH-1]};
  assign w_diff    = w_p_shift - {1'b0, r_d};
  assign w_p_next  = w_diff[WIDTH] ? w_p_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_q_next  = {r_q[WIDTH-2:0], ~w_diff[WIDTH]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.Run) begin
          w_next = w_div_zero ? S_HALT : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (w_last) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          w_next = S_FIXUP;
`else
          w_next = S_HALT;
`endif
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      S_FIXUP: begin
        w_next = S_HALT;
      end
`endif
      S_HALT: begin
        if (!bus.Run) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_p     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_count <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Run) begin
            r_p     <= '0;
            r_q     <= w_a_mag;
            r_d     <= w_b_mag;
            r_count <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
`endif
            if (w_div_zero) begin
              r_dbz  <= 1'b1;
              r_quot <= '1;
              r_rem  <= bus.Dividend;
            end else begin
              r_dbz  <= 1'b0;
            end
          end
        end
        S_COMPUTE: begin
          r_p     <= w_p_next;
          r_q     <= w_q_next;
          r_count <= r_count + CW'(1);
`ifndef SEQ_DIVIDER_SIGNED_EN
          if (w_last) begin
            r_quot <= w_q_next;
            r_rem  <= w_p_next;
          end
`endif
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        // Truncation toward zero: remainder follows the dividend's sign.
        S_FIXUP: begin
          r_quot <= (r_a_neg ^ r_b_neg) ? -r_q : r_q;
          r_rem  <= r_a_neg ? -r_p : r_p;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign bus.Quotient  = r_quot;
  assign bus.Remainder = r_rem;
  assign bus.DivByZero = r_dbz;
  assign bus.Done      = (r_state == S_HALT);

endmodule

// File: tb/tb_seq_divider.sv
// Randomized bench for seq_divider: per-cycle comparison against an arithmetic
// reference model plus hand-computed directed cases.
module tb_seq_divider;
  localparam int unsigned WIDTH = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int unsigned LAT = WIDTH + 2;
`else
  localparam int unsigned LAT = WIDTH + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  function automatic void check(input string name, input longint unsigned act,
                                input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    q  = WIDTH'(sa / sb);
    r  = WIDTH'(sa % sb);
`else
    q = a / b;
    r = a % b;
`endif
  endfunction

  // Reference model: tracks only what the outputs must show, from the transaction arithmetic.
  logic             m_armed = 1'b0;
  logic             m_done  = 1'b0;
  logic             m_dbz   = 1'b0;
  logic [WIDTH-1:0] m_q     = '0;
  logic [WIDTH-1:0] m_r     = '0;
  logic [WIDTH-1:0] p_q     = '0;
  logic [WIDTH-1:0] p_r     = '0;
  int               m_left  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_armed = 1'b1;
      m_done  = 1'b0;
      m_dbz   = 1'b0;
      m_q     = '0;
      m_r     = '0;
      m_left  = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_q    = p_q;
        m_r    = p_r;
        m_done = 1'b1;
      end
    end else if (m_done) begin
      if (!bus.Run) m_done = 1'b0;
    end else if (bus.Run) begin
      if (bus.Divisor == '0) begin
        m_dbz  = 1'b1;
        m_q    = '1;
        m_r    = bus.Dividend;
        m_done = 1'b1;
      end else begin
        m_dbz  = 1'b0;
        ref_div(bus.Dividend, bus.Divisor, p_q, p_r);
        m_left = LAT - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      check("Done",      bus.Done,      m_done);
      check("Quotient",  bus.Quotient,  m_q);
      check("Remainder", bus.Remainder, m_r);
      check("DivByZero", bus.DivByZero, m_dbz);
    end
  end

  task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(posedge clk);
    #2;
    bus.Dividend = a;
    bus.Divisor  = b;
    bus.Run      = 1'b1;
  endtask

  // Operands are scrambled right after the start edge; the result must not follow them.
  task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int hold);
    int edges;
    start(a, b);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin
        if (hold == 0) bus.Run = 1'b0;
        bus.Dividend = WIDTH'($urandom);
        bus.Divisor  = WIDTH'($urandom);
      end
    end while (!bus.Done && edges < 40);
    check("latency", edges, (b == '0) ? 1 : LAT);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_done", bus.Done, 1);
    end
    bus.Run = 1'b0;
    @(posedge clk);
    #1;
    check("idle_done", bus.Done, 0);
  endtask

  task automatic expect_res(input string name, input logic [WIDTH-1:0] q,
                            input logic [WIDTH-1:0] r, input logic dbz);
    check({name, "_q"},   bus.Quotient,  q);
    check({name, "_r"},   bus.Remainder, r);
    check({name, "_dbz"}, bus.DivByZero, dbz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bus.Run      = 1'b0;
    bus.Dividend = '0;
    bus.Divisor  = '0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_res("reset", 8'h00, 8'h00, 1'b0);
    check("reset_done", bus.Done, 0);
    rst = 1'b0;

`ifndef SEQ_DIVIDER_SIGNED_EN
    run_div(8'd200, 8'd7, 0);    expect_res("200/7",   8'd28,  8'd4,  1'b0);
    run_div(8'd5, 8'd9, 0);      expect_res("5/9",     8'd0,   8'd5,  1'b0);
    run_div(8'd255, 8'd1, 0);    expect_res("255/1",   8'd255, 8'd0,  1'b0);
    run_div(8'd255, 8'd255, 0);  expect_res("255/255", 8'd1,   8'd0,  1'b0);
    run_div(8'd77, 8'd0, 0);     expect_res("77/0",    8'hFF,  8'd77, 1'b1);
    run_div(8'd10, 8'd3, 0);     expect_res("10/3",    8'd3,   8'd1,  1'b0);
    run_div(8'd13, 8'd4, 5);     expect_res("13/4h",   8'd3,   8'd1,  1'b0);
`else
    run_div(8'h9C, 8'd7, 0);     expect_res("-100/7",  8'hF2,  8'hFE, 1'b0);
    run_div(8'h80, 8'hFF, 0);    expect_res("-128/-1", 8'h80,  8'h00, 1'b0);
    run_div(8'h64, 8'hF9, 0);    expect_res("100/-7",  8'hF2,  8'h02, 1'b0);
    run_div(8'd77, 8'd0, 0);     expect_res("77/0",    8'hFF,  8'd77, 1'b1);
    run_div(8'd10, 8'd3, 3);     expect_res("10/3h",   8'd3,   8'd1,  1'b0);
`endif

    // Reset lands on the 4th COMPUTE edge: the pending result is discarded.
    start(8'd50, 8'd3);
    repeat (4) @(posedge clk);
    #1;
    rst     = 1'b1;
    bus.Run = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_res("midreset", 8'd0, 8'd0, 1'b0);
    check("midreset_done", bus.Done, 0);
    run_div(8'd100, 8'd10, 0);   expect_res("100/10",  8'd10,  8'd0,  1'b0);

    for (int i = 0; i < 150; i++) begin
      a = WIDTH'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      if ($urandom_range(0, 9) == 0) b = 8'd1;
      run_div(a, b, int'($urandom_range(0, 2)));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
